riscv_dtm_tap: RTL and testbench
================================

Name: riscv_dtm_tap

Overview:
- RISC-V Debug Transport Module (DTM) behind the JTAG debug bridge. Consumes the bridge's target-side JTAG outputs (TCK, TMS, TDI, TRSTB) and returns TDO.
- Implements the IEEE 1149.1 TAP state machine, a 5-bit IR, and the IDCODE, DTMCS, DMI and BYPASS data registers.
- Issues DMI read/write requests to the debug module over a valid/ready handshake in the TCK domain. Any clock-domain crossing to the core clock lives in a separate block.

Parameters:
- IDCODE_VALUE, 32'h1000_0CFD, value captured by the IDCODE register; bit 0 must be 1.
- ABITS, 7, DMI address width (range 7..32).
- IDLE_HINT, 3'd1, DTMCS.idle field (minimum Run-Test/Idle cycles).

Ports:
- TCK  in  1  JTAG clock; the only clock; all flops on rising edge.
- TRSTB  in  1  asynchronous active-low reset.
- TMS  in  1  TAP mode select.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out.
- dmi_req_valid  out  1  DMI request valid.
- dmi_req_ready  in  1  DM accepts the request.
- dmi_req_addr  out  ABITS  DMI address.
- dmi_req_data  out  32  DMI write data.
- dmi_req_op  out  2  1=read, 2=write.
- dmi_resp_valid  in  1  DM response valid.
- dmi_resp_ready  out  1  DTM accepts the response.
- dmi_resp_data  in  32  read data.
- dmi_resp_resp  in  2  0=ok; any nonzero value = failed.
- dmi_hard_reset  out  1  one-cycle pulse requesting a DM hard reset.

Behaviour:
- Reset (TRSTB=0, async):
  - TAP state = Test-Logic-Reset; IR=5'h01 (IDCODE).
  - Sticky status = 0; no request outstanding.
  - All outputs 0.
- TAP FSM: standard 16 states, next state from TMS on each rising TCK. Entering Test-Logic-Reset (five TMS=1 clocks) has the same effect as TRSTB, including dropping any outstanding request.
- IR:
  - Capture-IR loads 5'b00001.
  - Shift-IR shifts LSB-first (TDI enters at the MSB).
  - Update-IR latches the shifted value.
  - Decode: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI; every other value selects the 1-bit BYPASS register.
- TDO:
  - In Shift-IR/Shift-DR, TDO = combinational LSB of the selected shift register.
  - Elsewhere TDO = 0.
  - BYPASS captures 0.
- DTMCS (32 bits) captures:
  - {14'b0, 2'b00 (dmihardreset, dmireset), 1'b0, IDLE_HINT, dmistat, ABITS[5:0], 4'h1}.
  - dmistat = sticky status.
  - At defaults the captured value is 0x0000_1071.
  - Update-DR: bit16=1 clears sticky. Bit17=1 clears sticky, abandons any outstanding request (dmi_req_valid drops next cycle, a pending response is discarded) and pulses dmi_hard_reset for 1 cycle. All other written bits are ignored.
- DMI (ABITS+34 bits = {addr, data[31:0], op[1:0]}):
  - Capture-DR loads {last_addr, resp_data_reg, op_status}.
  - op_status = 3 if a request is outstanding (which also sets sticky=3 if sticky was 0); otherwise op_status = sticky.
  - Update-DR with sticky≠0: ignored.
  - Update-DR with a request outstanding: ignored, sticky=3.
  - Update-DR with op=0: no action.
  - Update-DR with op=1/2: latch addr/data/op; dmi_req_valid=1 on the next cycle and held with stable payload until dmi_req_valid&dmi_req_ready.
  - Update-DR with op=3: treated as nop.
- Response:
  - After the request handshake, dmi_resp_ready=1 until dmi_resp_valid.
  - On the handshake, resp_data_reg <= dmi_resp_data (read only; writes leave it unchanged).
  - If dmi_resp_resp≠0 and sticky=0, sticky=2.
  - A request is outstanding from Update-DR through the response handshake.
  - dmi_resp_valid arriving while not waiting is ignored.
- Simultaneous events:
  - Response handshake and Capture-DR in the same cycle: capture sees the request as outstanding (op=3, busy is set).
  - dmihardreset in the same cycle as a response: the response is discarded.
- Sticky priority: the first error to occur wins; once set, sticky is changed only by a dmireset/dmihardreset write, Test-Logic-Reset, or TRSTB.

Test Plan:
- TRSTB pulse, then Shift-DR 32 bits with no IR load -> TDO bits equal IDCODE_VALUE LSB-first (0x1000_0CFD).
- IR=0x1F, shift 8'hA5 through DR -> TDO reproduces the pattern delayed one clock; Capture-IR produces 5'b00001 on TDO.
- IR=0x10, capture -> shifted-out value 0x0000_1071.
- IR=0x11, shift {addr=7'h10, data=0xDEADBEEF, op=2} with ready held 3 cycles low -> req_valid stable across the stall; one accepted request with the exact payload. Response ok, then a nop scan -> op_status 0.
- Read addr 7'h11, response delayed 10 TCK, re-scan at once -> captured op=3, sticky=3, the following Update-DR is ignored. DTMCS write bit16 -> dmistat=0, a new request is accepted.
- Read returning resp=2 -> next capture op=2 with data unchanged. DTMCS write bit17 -> dmi_hard_reset high exactly 1 cycle, dmistat=0.

Source files
------------

// File: rtl/riscv_dtm_tap.sv
// RISC-V debug transport module: IEEE 1149.1 TAP with IDCODE, DTMCS, DMI and BYPASS
// registers, issuing DMI requests to the debug module over a valid/ready handshake in TCK.
module riscv_dtm_tap #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0CFD,
    parameter int          ABITS        = 7,
    parameter logic [2:0]  IDLE_HINT    = 3'd1
) (
    input  logic             TCK,
    input  logic             TRSTB,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_resp,
    output logic             dmi_hard_reset
);
    localparam int          DRW         = ABITS + 34;
    localparam logic [5:0]  ABITS_FIELD = 6'(ABITS);
    localparam logic [4:0]  IR_IDCODE   = 5'h01;
    localparam logic [4:0]  IR_DTMCS    = 5'h10;
    localparam logic [4:0]  IR_DMI      = 5'h11;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE,
        SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_state_t;

    tap_state_t     state, state_next;
    logic [4:0]     ir, ir_shift;
    logic [DRW-1:0] dr;
    logic [1:0]     sticky;
    logic           busy;
    logic [31:0]    resp_data_reg;
    logic [31:0]    dtmcs_value;
    logic [1:0]     op_status;
    logic           hard_reset_wr, sticky_clr_wr, dmi_update, req_hs, resp_hs;

    assign dtmcs_value   = {14'b0, 2'b00, 1'b0, IDLE_HINT, sticky, ABITS_FIELD, 4'h1};
    assign op_status     = busy ? 2'd3 : sticky;
    assign hard_reset_wr = (state == UPDATE_DR) && (ir == IR_DTMCS) && dr[17];
    assign sticky_clr_wr = (state == UPDATE_DR) && (ir == IR_DTMCS) && dr[16];
    assign dmi_update    = (state == UPDATE_DR) && (ir == IR_DMI);
    assign req_hs        = dmi_req_valid && dmi_req_ready;
    // A hard-reset write in the same cycle as a response throws that response away.
    assign resp_hs       = dmi_resp_ready && dmi_resp_valid && !hard_reset_wr;

    assign TDO = (state == SHIFT_IR) ? ir_shift[0] :
                 (state == SHIFT_DR) ? dr[0] : 1'b0;

    always_ff @(posedge TCK or negedge TRSTB) begin
        if (!TRSTB) state <= TEST_LOGIC_RESET;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TEST_LOGIC_RESET: state_next = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_next = TMS ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        state_next = TMS ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       state_next = TMS ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR:         state_next = TMS ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:         state_next = TMS ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         state_next = TMS ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:         state_next = TMS ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        state_next = TMS ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        state_next = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_next = TMS ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR:         state_next = TMS ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:         state_next = TMS ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         state_next = TMS ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:         state_next = TMS ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        state_next = TMS ? SELECT_DR : RUN_TEST_IDLE;
            default:          state_next = TEST_LOGIC_RESET;
        endcase
    end

    always_ff @(posedge TCK or negedge TRSTB) begin
        if (!TRSTB) begin
            ir       <= IR_IDCODE;
            ir_shift <= '0;
        end else if (state == TEST_LOGIC_RESET) begin
            ir       <= IR_IDCODE;
            ir_shift <= '0;
        end else begin
            case (state)
                CAPTURE_IR: ir_shift <= 5'b00001;
                SHIFT_IR:   ir_shift <= {TDI, ir_shift[4:1]};
                UPDATE_IR:  ir       <= ir_shift;
                default:    ;
            endcase
        end
    end

    // One shared data shift register; TDI enters at the MSB of whichever register is selected.
    always_ff @(posedge TCK or negedge TRSTB) begin
        if (!TRSTB) begin
            dr <= '0;
        end else if (state == CAPTURE_DR) begin
            case (ir)
                IR_IDCODE: dr <= {{(DRW-32){1'b0}}, IDCODE_VALUE};
                IR_DTMCS:  dr <= {{(DRW-32){1'b0}}, dtmcs_value};
                IR_DMI:    dr <= {dmi_req_addr, resp_data_reg, op_status};
                default:   dr <= '0;
            endcase
        end else if (state == SHIFT_DR) begin
            case (ir)
                IR_IDCODE, IR_DTMCS: dr[31:0] <= {TDI, dr[31:1]};
                IR_DMI:              dr       <= {TDI, dr[DRW-1:1]};
                default:             dr[0]    <= TDI;
            endcase
        end
    end

    // Later assignments take priority: capture-busy over response error, hard reset over all.
    always_ff @(posedge TCK or negedge TRSTB) begin
        if (!TRSTB) begin
            sticky         <= '0;
            busy           <= 1'b0;
            dmi_req_valid  <= 1'b0;
            dmi_req_addr   <= '0;
            dmi_req_data   <= '0;
            dmi_req_op     <= '0;
            dmi_resp_ready <= 1'b0;
            dmi_hard_reset <= 1'b0;
            resp_data_reg  <= '0;
        end else if (state == TEST_LOGIC_RESET) begin
            sticky         <= '0;
            busy           <= 1'b0;
            dmi_req_valid  <= 1'b0;
            dmi_req_addr   <= '0;
            dmi_req_data   <= '0;
            dmi_req_op     <= '0;
            dmi_resp_ready <= 1'b0;
            dmi_hard_reset <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            dmi_hard_reset <= 1'b0;
            if (req_hs) begin
                dmi_req_valid  <= 1'b0;
                dmi_resp_ready <= 1'b1;
            end
            if (resp_hs) begin
                dmi_resp_ready <= 1'b0;
                busy           <= 1'b0;
                if (dmi_req_op == 2'd1 && dmi_resp_resp == 2'd0) resp_data_reg <= dmi_resp_data;
                if (dmi_resp_resp != 2'd0 && sticky == 2'd0) sticky <= 2'd2;
            end
            if (state == CAPTURE_DR && ir == IR_DMI && busy && sticky == 2'd0) sticky <= 2'd3;
            if (dmi_update && sticky == 2'd0) begin
                if (busy) begin
                    sticky <= 2'd3;
                end else if (dr[1:0] == 2'd1 || dr[1:0] == 2'd2) begin
                    busy          <= 1'b1;
                    dmi_req_valid <= 1'b1;
                    dmi_req_addr  <= dr[DRW-1:34];
                    dmi_req_data  <= dr[33:2];
                    dmi_req_op    <= dr[1:0];
                end
            end
            if (sticky_clr_wr) sticky <= 2'd0;
            if (hard_reset_wr) begin
                sticky         <= 2'd0;
                busy           <= 1'b0;
                dmi_req_valid  <= 1'b0;
                dmi_resp_ready <= 1'b0;
                dmi_hard_reset <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_riscv_dtm_tap.sv
// Bench for riscv_dtm_tap: directed JTAG scans, a queue-based transaction model checked
// every cycle, and literal expectations for the captured scan values.
module tb_riscv_dtm_tap;
    localparam int          AB      = 7;
    localparam int          DMI_LEN = AB + 34;
    localparam logic [31:0] IDCODE  = 32'h1000_0CFD;
    localparam logic [4:0]  IR_IDC  = 5'h01;
    localparam logic [4:0]  IR_DTM  = 5'h10;
    localparam logic [4:0]  IR_DMI  = 5'h11;
    localparam int T_TLR = 0, T_RTI = 1, T_CDR = 3, T_SHDR = 4, T_UDR = 8;
    localparam int T_CIR = 10, T_SHIR = 11, T_UIR = 15;

    logic          TCK = 1'b0, TRSTB = 1'b1, TMS = 1'b0, TDI = 1'b0;
    logic          TDO;
    logic          dmi_req_valid, dmi_req_ready = 1'b0;
    logic [AB-1:0] dmi_req_addr;
    logic [31:0]   dmi_req_data;
    logic [1:0]    dmi_req_op;
    logic          dmi_resp_valid = 1'b0, dmi_resp_ready;
    logic [31:0]   dmi_resp_data = '0;
    logic [1:0]    dmi_resp_resp = '0;
    logic          dmi_hard_reset;

    riscv_dtm_tap dut (
        .TCK(TCK), .TRSTB(TRSTB), .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_data(dmi_resp_data), .dmi_resp_resp(dmi_resp_resp),
        .dmi_hard_reset(dmi_hard_reset)
    );

    always #5 TCK = ~TCK;

    int n_cmp = 0, n_bad = 0;
    int hard_cnt = 0, hs_cnt = 0;
    bit check_en = 1'b0;
    logic tdo_sample;

    // TAP transition table indexed by current state, one row per TMS value.
    int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int            m_tap;
    logic [4:0]    m_ir;
    bit            m_q [$];
    logic [1:0]    m_sticky, m_op;
    bit            m_busy, m_req_valid, m_resp_ready, m_hard;
    logic [AB-1:0] m_addr;
    logic [31:0]   m_data, m_rdata;

    int          ready_delay = 0, resp_delay = 0;
    logic [31:0] resp_data_cfg = '0;
    logic [1:0]  resp_resp_cfg = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] q_value();
        logic [63:0] v = '0;
        for (int i = 0; i < m_q.size() && i < 64; i++) v[i] = m_q[i];
        return v;
    endfunction

    task automatic load_q(input logic [63:0] v, input int len);
        m_q.delete();
        for (int i = 0; i < len; i++) m_q.push_back(v[i]);
    endtask

    function automatic bit exp_tdo();
        if ((m_tap == T_SHDR || m_tap == T_SHIR) && m_q.size() > 0) return m_q[0];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_ir = IR_IDC; m_sticky = 0; m_op = 0; m_busy = 0; m_req_valid = 0;
        m_resp_ready = 0; m_hard = 0; m_addr = 0; m_data = 0; m_rdata = 0;
    endtask

    // Transaction-level model of one TCK rising edge, using only pre-edge model values and bench inputs.
    task automatic model_step();
        logic [63:0]   w;
        logic [63:0]   cap;
        logic [1:0]    opst, n_sticky;
        logic [4:0]    n_ir;
        logic [AB-1:0] n_addr;
        logic [31:0]   n_data, n_rdata;
        logic [1:0]    n_op;
        bit            hard, rq_hs, rs_hs, n_busy, n_req_valid, n_resp_ready;
        int            cur;
        cur = m_tap;
        m_tap = TMS ? nx1[cur] : nx0[cur];
        if (cur == T_TLR) begin
            model_reset();
            return;
        end
        w = q_value();
        n_sticky = m_sticky; n_ir = m_ir; n_addr = m_addr; n_data = m_data; n_op = m_op;
        n_rdata = m_rdata; n_busy = m_busy; n_req_valid = m_req_valid; n_resp_ready = m_resp_ready;
        hard  = (cur == T_UDR) && (m_ir == IR_DTM) && w[17];
        rq_hs = m_req_valid && dmi_req_ready;
        rs_hs = m_resp_ready && dmi_resp_valid && !hard;
        if (rq_hs) begin n_req_valid = 0; n_resp_ready = 1; end
        if (rs_hs) begin
            n_resp_ready = 0; n_busy = 0;
            if (m_op == 2'd1 && dmi_resp_resp == 0) n_rdata = dmi_resp_data;
            if (dmi_resp_resp != 0 && m_sticky == 0) n_sticky = 2;
        end
        case (cur)
            T_CIR: load_q(64'd1, 5);
            T_SHIR, T_SHDR: begin m_q.push_back(TDI); void'(m_q.pop_front()); end
            T_UIR: n_ir = w[4:0];
            T_CDR: begin
                if (m_ir == IR_IDC) load_q({32'd0, IDCODE}, 32);
                else if (m_ir == IR_DTM) begin
                    cap = (64'd1 << 12) + (64'(m_sticky) << 10) + (64'(AB) << 4) + 64'd1;
                    load_q(cap, 32);
                end else if (m_ir == IR_DMI) begin
                    opst = m_busy ? 2'd3 : m_sticky;
                    if (m_busy && m_sticky == 0) n_sticky = 3;
                    cap = (64'(m_addr) << 34) + (64'(m_rdata) << 2) + 64'(opst);
                    load_q(cap, DMI_LEN);
                end else load_q(64'd0, 1);
            end
            T_UDR: begin
                if (m_ir == IR_DTM && w[16]) n_sticky = 0;
                if (m_ir == IR_DMI && m_sticky == 0) begin
                    if (m_busy) n_sticky = 3;
                    else if (w[1:0] == 2'd1 || w[1:0] == 2'd2) begin
                        n_busy = 1; n_req_valid = 1;
                        n_op = w[1:0]; n_data = w[33:2]; n_addr = AB'(w >> 34);
                    end
                end
            end
            default: ;
        endcase
        if (hard) begin n_sticky = 0; n_busy = 0; n_req_valid = 0; n_resp_ready = 0; end
        m_hard = hard; m_sticky = n_sticky; m_ir = n_ir; m_addr = n_addr; m_data = n_data;
        m_op = n_op; m_rdata = n_rdata; m_busy = n_busy; m_req_valid = n_req_valid;
        m_resp_ready = n_resp_ready;
    endtask

    task automatic applyStimulus(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(negedge TCK);
        tdo_sample = TDO;
        @(posedge TCK);
        model_step();
        #1;
    endtask

    task automatic scanIr(input logic [4:0] din, output logic [4:0] dout);
        dout = '0;
        applyStimulus(1, 0); applyStimulus(1, 0); applyStimulus(0, 0); applyStimulus(0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 4, din[i]);
            dout[i] = tdo_sample;
        end
        applyStimulus(1, 0); applyStimulus(0, 0);
    endtask

    task automatic scanDr(input int len, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        applyStimulus(1, 0); applyStimulus(0, 0); applyStimulus(0, 0);
        for (int i = 0; i < len; i++) begin
            applyStimulus(i == len - 1, din[i]);
            dout[i] = tdo_sample;
        end
        applyStimulus(1, 0); applyStimulus(0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0);
    endtask

    // Debug-module responder: delays ready and response by the configured cycle counts.
    initial begin
        int rcnt = 0, pcnt = 0;
        forever begin
            @(posedge TCK);
            #1;
            dmi_resp_data = resp_data_cfg;
            dmi_resp_resp = resp_resp_cfg;
            if (m_req_valid) begin dmi_req_ready = (rcnt >= ready_delay); rcnt++; end
            else begin dmi_req_ready = 1'b0; rcnt = 0; end
            if (m_resp_ready) begin dmi_resp_valid = (pcnt >= resp_delay); pcnt++; end
            else begin dmi_resp_valid = 1'b0; pcnt = 0; end
        end
    end

    initial begin
        forever begin
            @(negedge TCK);
            if (check_en) begin
                checkOutput("tdo", 64'(TDO), 64'(exp_tdo()));
                checkOutput("req_valid", 64'(dmi_req_valid), 64'(m_req_valid));
                checkOutput("resp_ready", 64'(dmi_resp_ready), 64'(m_resp_ready));
                checkOutput("hard_reset", 64'(dmi_hard_reset), 64'(m_hard));
                if (m_req_valid) begin
                    checkOutput("req_addr", 64'(dmi_req_addr), 64'(m_addr));
                    checkOutput("req_data", 64'(dmi_req_data), 64'(m_data));
                    checkOutput("req_op", 64'(dmi_req_op), 64'(m_op));
                end
                if (dmi_hard_reset) hard_cnt++;
                if (dmi_req_valid && dmi_req_ready) hs_cnt++;
            end
        end
    end

    initial begin
        logic [4:0]  iro;
        logic [63:0] dro;
        #1;
        TRSTB = 1'b0;
        model_reset();
        m_tap = T_TLR;
        m_q.delete();
        repeat (2) @(posedge TCK);
        #1;
        TRSTB = 1'b1;
        check_en = 1'b1;
        checkOutput("rst_tdo", 64'(TDO), 64'd0);
        checkOutput("rst_req_valid", 64'(dmi_req_valid), 64'd0);
        checkOutput("rst_resp_ready", 64'(dmi_resp_ready), 64'd0);
        checkOutput("rst_hard_reset", 64'(dmi_hard_reset), 64'd0);

        applyStimulus(0, 0);
        scanDr(32, 64'd0, dro);
        checkOutput("idcode_after_reset", dro, 64'h1000_0CFD);

        scanIr(5'h1F, iro);
        checkOutput("capture_ir_bypass", 64'(iro), 64'd1);
        scanDr(9, 64'h0A5, dro);
        checkOutput("bypass_delay", dro, 64'h14A);

        scanIr(IR_DTM, iro);
        checkOutput("capture_ir_dtmcs", 64'(iro), 64'd1);
        scanDr(32, 64'd0, dro);
        checkOutput("dtmcs_default", dro, 64'h1071);

        scanIr(IR_DMI, iro);
        ready_delay = 3; resp_delay = 2; resp_data_cfg = 32'hFFFF_FFFF; resp_resp_cfg = 2'd0;
        scanDr(DMI_LEN, {23'd0, 7'h10, 32'hDEAD_BEEF, 2'd2}, dro);
        checkOutput("dmi_first_capture", dro, 64'd0);
        idle(12);
        scanDr(DMI_LEN, 64'd0, dro);
        checkOutput("dmi_write_done", dro, {23'd0, 7'h10, 32'h0, 2'd0});

        ready_delay = 0; resp_delay = 10; resp_data_cfg = 32'hCAFE_F00D; resp_resp_cfg = 2'd0;
        scanDr(DMI_LEN, {23'd0, 7'h11, 32'h0, 2'd1}, dro);
        checkOutput("dmi_read_issue", dro, {23'd0, 7'h10, 32'h0, 2'd0});
        scanDr(DMI_LEN, {23'd0, 7'h22, 32'h0, 2'd1}, dro);
        checkOutput("dmi_busy_capture", dro, {23'd0, 7'h11, 32'h0, 2'd3});

        scanIr(IR_DTM, iro);
        scanDr(32, 64'h1_0000, dro);
        checkOutput("dtmcs_busy_sticky", dro, 64'h1C71);

        scanIr(IR_DMI, iro);
        ready_delay = 1; resp_delay = 1; resp_data_cfg = 32'h55AA_55AA; resp_resp_cfg = 2'd2;
        scanDr(DMI_LEN, {23'd0, 7'h05, 32'h0, 2'd1}, dro);
        checkOutput("dmi_after_clear", dro, {23'd0, 7'h11, 32'hCAFE_F00D, 2'd0});
        idle(8);
        scanDr(DMI_LEN, 64'd0, dro);
        checkOutput("dmi_failed_read", dro, {23'd0, 7'h05, 32'hCAFE_F00D, 2'd2});

        scanIr(IR_DTM, iro);
        scanDr(32, 64'h2_0000, dro);
        checkOutput("dtmcs_failed_sticky", dro, 64'h1871);
        scanDr(32, 64'd0, dro);
        checkOutput("dtmcs_after_hard_reset", dro, 64'h1071);

        scanIr(IR_DMI, iro);
        ready_delay = 0; resp_delay = 40; resp_resp_cfg = 2'd0;
        scanDr(DMI_LEN, {23'd0, 7'h33, 32'h0, 2'd1}, dro);
        checkOutput("dmi_post_hard_reset", dro, {23'd0, 7'h05, 32'hCAFE_F00D, 2'd0});
        idle(3);
        checkOutput("waiting_response", 64'(dmi_resp_ready), 64'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0);
        applyStimulus(0, 0);
        checkOutput("tlr_drops_resp_ready", 64'(dmi_resp_ready), 64'd0);
        scanDr(32, 64'd0, dro);
        checkOutput("idcode_after_tlr", dro, 64'h1000_0CFD);

        checkOutput("hard_reset_cycles", 64'(hard_cnt), 64'd1);
        checkOutput("request_handshakes", 64'(hs_cnt), 64'd4);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
